// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the column-serial Wallace multiplier
package mul_seq_pkg;
  localparam int MUL_SEQ_W       = 8;
  localparam int MUL_SEQ_COL_NUM = 16;
  localparam int MUL_SEQ_COL_W   = $clog2(MUL_SEQ_COL_NUM);
  localparam int MUL_SEQ_CRY_W   = 6;
  typedef enum logic [1:0] {S_IDLE, S_COL, S_DONE} mul_seq_state_e;
endpackage

// File: rtl/add_01bit_full.sv
// add_01bit_full: single-bit full adder
module add_01bit_full (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cry
);
  assign o_sum = i_a ^ i_b ^ i_cin;
  assign o_cry = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

// File: rtl/mul_01bitx08_wallace.sv
// mul_01bitx08_wallace: one product column, 8 partial products plus 6 incoming carries
// reduced to a sum/carry pair and 6 carries into the next column.
module mul_01bitx08_wallace (
  input  logic [7:0] i_num,
  input  logic [5:0] i_cry_06bit,
  output logic       o_res,
  output logic       o_cry,
  output logic [5:0] o_cry_06bit
);
  logic w_s0, w_s1, w_s2, w_s3, w_s4, w_s5;
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction
  // incoming carries enter at the later tree levels to balance depth
  assign {o_cry_06bit[0], w_s0} = fa(i_num[0], i_num[1], i_num[2]);
  assign {o_cry_06bit[1], w_s1} = fa(i_num[3], i_num[4], i_num[5]);
  assign {o_cry_06bit[2], w_s2} = fa(w_s0, w_s1, i_num[6]);
  assign {o_cry_06bit[3], w_s3} = fa(i_num[7], i_cry_06bit[0], i_cry_06bit[1]);
  assign {o_cry_06bit[4], w_s4} = fa(w_s2, w_s3, i_cry_06bit[2]);
  assign {o_cry_06bit[5], w_s5} = fa(i_cry_06bit[3], i_cry_06bit[4], i_cry_06bit[5]);
  assign o_res = w_s4 ^ w_s5;
  assign o_cry = w_s4 & w_s5;
endmodule

// File: rtl/mul_08bitx08_wallace_seq.sv
// mul_08bitx08_wallace_seq: column-serial 8x8 multiplier, one Wallace column per cycle.
// Define MUL_SEQ_SIGNED_EN for the i_sign port and Baugh-Wooley signed products.
module mul_08bitx08_wallace_seq
  import mul_seq_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [MUL_SEQ_W-1:0]     i_mul_a,
  input  logic [MUL_SEQ_W-1:0]     i_mul_b,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic                     i_sign,
`endif
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*MUL_SEQ_W-1:0]   o_res,
  output logic                     o_busy
);
  mul_seq_state_e r_state, w_state_nxt;
  logic [MUL_SEQ_W-1:0] r_a, r_b, w_pp;
  logic [MUL_SEQ_COL_W-1:0] r_col;
  logic [MUL_SEQ_CRY_W-1:0] r_cry_06bit, w_cry_06bit;
  logic [2*MUL_SEQ_W-1:0] r_res;
  logic r_c_prev, r_add_cry, w_slice_res, w_slice_cry, w_add_sum, w_add_cry, w_sign, w_accept;
  function automatic logic [MUL_SEQ_W-1:0] pp_gate(input logic [MUL_SEQ_W-1:0] a,
      input logic [MUL_SEQ_W-1:0] b, input logic [MUL_SEQ_COL_W-1:0] k, input logic sgn);
    logic [MUL_SEQ_W-1:0] pp;
    int j;
    pp = '0;
    for (int i = 0; i < MUL_SEQ_W; i++) begin
      j = int'(k) - i;
      if (j >= 0 && j < MUL_SEQ_W)
        pp[i] = (a[i] & b[j[2:0]]) ^ (sgn & ((i == MUL_SEQ_W - 1) != (j == MUL_SEQ_W - 1)));
    end
    // Baugh-Wooley correction constants 2^8 and 2^15 use the otherwise empty pp[0] slot
    if (sgn && (k == 4'd8 || k == 4'd15)) pp[0] = 1'b1;
    return pp;
  endfunction
`ifdef MUL_SEQ_SIGNED_EN
  logic r_sign;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sign <= 1'b0;
    else if (w_accept) r_sign <= i_sign;
  assign w_sign = r_sign;
`else
  assign w_sign = 1'b0;
`endif
  assign w_accept = i_valid && o_ready;
  assign w_pp = pp_gate(r_a, r_b, r_col, w_sign);
  assign o_res = r_res;
  mul_01bitx08_wallace u_slice (
    .i_num       (w_pp),
    .i_cry_06bit (r_cry_06bit),
    .o_res       (w_slice_res),
    .o_cry       (w_slice_cry),
    .o_cry_06bit (w_cry_06bit)
  );
  add_01bit_full u_add (
    .i_a   (w_slice_res),
    .i_b   (r_c_prev),
    .i_cin (r_add_cry),
    .o_sum (w_add_sum),
    .o_cry (w_add_cry)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    o_ready = r_state == S_IDLE;
    o_busy = r_state == S_COL;
    o_valid = r_state == S_DONE;
    w_state_nxt = (o_ready && i_valid) ? S_COL :
                  (o_busy && r_col == MUL_SEQ_COL_W'(MUL_SEQ_COL_NUM - 1)) ? S_DONE :
                  (o_valid && i_ready) ? S_IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_col <= '0;
      r_cry_06bit <= '0;
      r_c_prev <= 1'b0;
      r_add_cry <= 1'b0;
      r_res <= '0;
    end else if (w_accept) begin
      r_a <= i_mul_a;
      r_b <= i_mul_b;
      r_col <= '0;
      r_cry_06bit <= '0;
      r_c_prev <= 1'b0;
      r_add_cry <= 1'b0;
      r_res <= '0;
    end else if (o_busy) begin
      r_res[r_col] <= w_add_sum;
      r_c_prev <= w_slice_cry;
      r_add_cry <= w_add_cry;
      r_cry_06bit <= w_cry_06bit;
      r_col <= r_col + 1'b1;
    end
endmodule

// File: tb/tb_mul_08bitx08_wallace_seq.sv
// tb_mul_08bitx08_wallace_seq: scoreboard bench, directed cases plus random operands
// checked against an integer-arithmetic reference.
module tb_mul_08bitx08_wallace_seq;
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 1, sign = 0;
  logic o_ready, o_valid, o_busy;
  logic [7:0] a = 0, b = 0;
  logic [15:0] o_res;
  int cyc = 0, checks = 0, passes = 0;
  typedef struct { logic [15:0] res; int acc; } exp_t;
  exp_t q[$];
  logic prev_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_08bitx08_wallace_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mul_a (a),
    .i_mul_b (b),
`ifdef MUL_SEQ_SIGNED_EN
    .i_sign  (sign),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_busy  (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    int sx, sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
    int n = 0;
    a = x; b = y; sign = s; i_valid = 1;
    while (!o_ready && n < 40) begin tick; n++; end
    chk("accept_ready", 32'(o_ready), 1);
    if (o_ready) q.push_back('{ref_mul(x, y, s), cyc + 1});
    tick;
    i_valid = 0; a = 8'($urandom); b = 8'($urandom); sign = 1'($urandom);
  endtask

  task automatic wait_done;
    int n = 0;
    while ((q.size() != 0 || !o_ready) && n < 200) begin tick; n++; end
    chk("drain", 32'(q.size() == 0 && o_ready), 1);
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!o_valid && n < 40) begin tick; n++; end
    chk("valid_seen", 32'(o_valid), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 1);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_res"}, 32'(o_res), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid && !prev_valid) begin
        chk("pending_on_valid", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("latency", 32'(cyc - q[0].acc), 16);
      end
      prev_valid = o_valid;
      if (o_valid && i_ready) begin
        chk("pending_on_xfer", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("product", 32'(o_res), 32'(e.res));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: cycle %0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    chk_reset_outputs("por");
    rst_n = 1;
    tick;
    do_mul(8'h0D, 8'h0B, 0); wait_done;
    do_mul(8'hFF, 8'hFF, 0); wait_done;
    i_ready = 0;
    do_mul(8'h00, 8'hA5, 0);
    wait_valid;
    i_valid = 1; a = 8'h11; b = 8'h22;
    repeat (3) begin
      tick;
      chk("no_accept_in_done", 32'(o_ready), 0);
      chk("not_busy_in_done", 32'(o_busy), 0);
    end
    i_valid = 0; i_ready = 1;
    wait_done;
    i_ready = 0;
    do_mul(8'h12, 8'h34, 0);
    wait_valid;
    repeat (10) begin
      tick;
      chk("bp_res", 32'(o_res), 32'h03A8);
      chk("bp_valid", 32'(o_valid), 1);
    end
    i_ready = 1;
    tick;
    chk("idle_after_xfer", 32'(o_ready), 1);
    chk("valid_drop", 32'(o_valid), 0);
    do_mul(8'h5A, 8'hC3, 0);
    repeat (7) tick;
    chk("busy_mid_col", 32'(o_busy), 1);
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_rst");
    q.delete();
    tick; tick;
    rst_n = 1;
    tick;
    do_mul(8'h03, 8'h05, 0); wait_done;
`ifdef MUL_SEQ_SIGNED_EN
    do_mul(8'h80, 8'hFF, 1); wait_done;
    do_mul(8'hFF, 8'h01, 1); wait_done;
    do_mul(8'h80, 8'h80, 1); wait_done;
    do_mul(8'h7F, 8'h80, 1); wait_done;
`endif
    repeat (24) begin
      int n;
`ifdef MUL_SEQ_SIGNED_EN
      do_mul(8'($urandom), 8'($urandom), 1'($urandom));
`else
      do_mul(8'($urandom), 8'($urandom), 0);
`endif
      n = 0;
      while ((q.size() != 0 || !o_ready) && n < 200) begin
        i_ready = ($urandom_range(0, 3) != 0);
        tick;
        n++;
      end
      i_ready = 1;
      chk("rand_drain", 32'(q.size() == 0 && o_ready), 1);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
